// File: rtl/tlb_walker_if.sv
// Bundle of the three channels around the page-table walker: miss request in,
// PTE read request/response out to memory, and fill entry back to the TLB.
interface tlb_walker_if #(
  parameter int PCID_W = 12,
  parameter int PPN_W  = 40,
  parameter int ADDR_W = 64
);
  // A transfer happens on a rising clk edge where valid and ready are both 1;
  // the source holds valid and its payload stable until that edge, and valid
  // never waits on ready. mem_rsp has no ready: the walker takes it in WAIT.
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_va;
  logic [PCID_W-1:0] req_pcid;
  logic [PPN_W-1:0]  root_ppn;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [63:0]       mem_rsp_data;

  logic              fill_valid;
  logic              fill_ready;
  logic [ADDR_W-1:0] fill_va;
  logic [PCID_W-1:0] fill_pcid;
  logic [ADDR_W-1:0] fill_pa;
  logic [1:0]        fill_level;
  logic              fill_fault;

  modport slave (
    input  req_valid, req_va, req_pcid, root_ppn,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  fill_ready,
    output req_ready, mem_req_valid, mem_req_addr,
    output fill_valid, fill_va, fill_pcid, fill_pa, fill_level, fill_fault
  );

  modport master (
    output req_valid, req_va, req_pcid, root_ppn,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output fill_ready,
    input  req_ready, mem_req_valid, mem_req_addr,
    input  fill_valid, fill_va, fill_pcid, fill_pa, fill_level, fill_fault
  );
endinterface

// File: rtl/tlb_walker.sv
// Four-level radix page-table walker (PML4/PDPT/PD/PT, 9 index bits per level)
// answering TLB misses with a fill entry; one walk and one memory read in flight.
module tlb_walker #(
  parameter int PCID_W = 12,
  parameter int PPN_W  = 40,
  parameter int ADDR_W = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  tlb_walker_if.slave bus,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    FILL  = 2'd3
  } state_e;

  state_e            state_q;
  logic              req_ready_q;
  logic              mem_req_valid_q;
  logic [ADDR_W-1:0] mem_req_addr_q;
  logic              fill_valid_q;
  logic [ADDR_W-1:0] fill_pa_q;
  logic [1:0]        fill_level_q;
  logic              fill_fault_q;
  logic [ADDR_W-1:0] va_q;
  logic [PCID_W-1:0] pcid_q;
  logic [1:0]        lvl_q;

  logic              req_canonical;
  logic [63:0]       pte;
  logic [PPN_W-1:0]  pte_ppn;
  logic              unused_pte_bits;

  function automatic logic [8:0] va_idx(input logic [35:0] vpn, input logic [1:0] lvl);
    logic [8:0] idx;
    case (lvl)
      2'd3:    idx = vpn[35:27];
      2'd2:    idx = vpn[26:18];
      2'd1:    idx = vpn[17:9];
      default: idx = vpn[8:0];
    endcase
    return idx;
  endfunction

  function automatic logic [ADDR_W-1:0] pte_addr(input logic [PPN_W-1:0] ppn, input logic [8:0] idx);
    return ADDR_W'({ppn, idx, 3'b000});
  endfunction

  // Large pages keep more of the VA as page offset and fewer PPN bits.
  function automatic logic [ADDR_W-1:0] leaf_pa(input logic [PPN_W-1:0] ppn, input logic [29:0] off,
                                                input logic [1:0] lvl);
    logic [PPN_W+11:0] pa;
    case (lvl)
      2'd2:    pa = {ppn[PPN_W-1:18], off[29:0]};
      2'd1:    pa = {ppn[PPN_W-1:9],  off[20:0]};
      default: pa = {ppn,             off[11:0]};
    endcase
    return ADDR_W'(pa);
  endfunction

  assign req_canonical   = (&bus.req_va[ADDR_W-1:47]) | ~(|bus.req_va[ADDR_W-1:47]);
  assign pte             = bus.mem_rsp_data;
  assign pte_ppn         = pte[12 +: PPN_W];
  assign unused_pte_bits = ^{pte[63:52], pte[11:8], pte[6:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      req_ready_q     <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      fill_valid_q    <= 1'b0;
      fill_pa_q       <= '0;
      fill_level_q    <= 2'd0;
      fill_fault_q    <= 1'b0;
      va_q            <= '0;
      pcid_q          <= '0;
      lvl_q           <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_ready_q && bus.req_valid) begin
            req_ready_q <= 1'b0;
            va_q        <= bus.req_va;
            pcid_q      <= bus.req_pcid;
            lvl_q       <= 2'd3;
            if (!req_canonical) begin
              state_q      <= FILL;
              fill_valid_q <= 1'b1;
              fill_fault_q <= 1'b1;
              fill_level_q <= 2'd3;
              fill_pa_q    <= '0;
            end else begin
              state_q         <= ISSUE;
              mem_req_valid_q <= 1'b1;
              mem_req_addr_q  <= pte_addr(bus.root_ppn, va_idx(bus.req_va[47:12], 2'd3));
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ISSUE: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_rsp_valid) begin
            if (!pte[0] || (pte[7] && lvl_q == 2'd3)) begin
              state_q      <= FILL;
              fill_valid_q <= 1'b1;
              fill_fault_q <= 1'b1;
              fill_level_q <= lvl_q;
              fill_pa_q    <= '0;
            end else if (lvl_q == 2'd0 || pte[7]) begin
              state_q      <= FILL;
              fill_valid_q <= 1'b1;
              fill_fault_q <= 1'b0;
              fill_level_q <= lvl_q;
              fill_pa_q    <= leaf_pa(pte_ppn, va_q[29:0], lvl_q);
            end else begin
              state_q         <= ISSUE;
              lvl_q           <= lvl_q - 2'd1;
              mem_req_valid_q <= 1'b1;
              mem_req_addr_q  <= pte_addr(pte_ppn, va_idx(va_q[47:12], lvl_q - 2'd1));
            end
          end
        end
        FILL: begin
          if (bus.fill_ready) begin
            fill_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_addr  = mem_req_addr_q;
  assign bus.fill_valid    = fill_valid_q;
  assign bus.fill_va       = va_q;
  assign bus.fill_pcid     = pcid_q;
  assign bus.fill_pa       = fill_pa_q;
  assign bus.fill_level    = fill_level_q;
  assign bus.fill_fault    = fill_fault_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_tlb_walker.sv
// Bench for tlb_walker: directed walks from the test plan plus randomized page
// tables and stalls, checked against an arithmetic page-walk model.
module tb_tlb_walker;
  localparam int PCID_W = 12;
  localparam int PPN_W  = 40;
  localparam int ADDR_W = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  tlb_walker_if #(.PCID_W(PCID_W), .PPN_W(PPN_W), .ADDR_W(ADDR_W)) bus();

  tlb_walker #(.PCID_W(PCID_W), .PPN_W(PPN_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] pt_mem [logic [63:0]];
  logic [63:0] exp_q[$];
  logic [63:0] seen_addr[$];
  localparam logic [63:0] PTE_PPN_MASK = 64'h000F_FFFF_FFFF_F000;

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    return pt_mem.exists(a) ? pt_mem[a] : 64'd0;
  endfunction

  // Reference walk: page sizes and offsets from plain shifts and masks.
  task automatic model_walk(input logic [63:0] va, input logic [39:0] root,
                            output logic [63:0] pa, output logic [1:0] level,
                            output logic fault, output int n);
    logic [63:0] base, a, pte, page;
    bit finished;
    exp_q.delete();
    pa = 64'd0; level = 2'd3; fault = 1'b1; n = 0; finished = 0;
    if (!(va[63:47] == 17'h0 || va[63:47] == 17'h1FFFF)) finished = 1;
    base = {24'd0, root} << 12;
    for (int l = 3; l >= 0 && !finished; l--) begin
      a = base + (((va >> (12 + 9 * l)) & 64'h1FF) * 8);
      exp_q.push_back(a);
      n++;
      pte = mem_rd(a);
      if (pte[0] == 1'b0) begin
        level = 2'(l); finished = 1;
      end else if (l == 3 && pte[7]) begin
        level = 2'd3; finished = 1;
      end else if (l == 0 || pte[7]) begin
        page  = 64'd1 << (12 + 9 * l);
        pa    = (pte & PTE_PPN_MASK & ~(page - 1)) | (va & (page - 1));
        level = 2'(l); fault = 1'b0; finished = 1;
      end else begin
        base = pte & PTE_PPN_MASK;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_walk(input logic [63:0] va, input logic [11:0] pcid, input logic [39:0] root,
                          input int mem_stall, input int rsp_delay, input int fill_stall,
                          output logic [63:0] o_pa, output logic [1:0] o_level,
                          output logic o_fault, output int o_nacc);
    logic [63:0] e_pa, a, e_a, f_va, f_pa;
    logic [1:0]  e_level, f_level;
    logic        e_fault, f_fault;
    logic [11:0] f_pcid;
    int          e_n, budget, c0;
    bit          done;
    model_walk(va, root, e_pa, e_level, e_fault, e_n);
    seen_addr.delete();
    o_pa = '0; o_level = '0; o_fault = 1'b0; o_nacc = 0;
    budget = 0;
    while (bus.req_ready !== 1'b1 && budget < 50) begin @(negedge clk); budget++; end
    n_checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL req_ready_idle: got %b want 1", bus.req_ready);
    else n_pass++;
    bus.req_valid = 1'b1; bus.req_va = va; bus.req_pcid = pcid; bus.root_ppn = root;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_va    = {$urandom, $urandom};
    bus.req_pcid  = 12'($urandom);
    bus.root_ppn  = {8'($urandom), 32'($urandom)};
    c0 = cyc;
    done = 0; budget = 0;
    while (!done && budget < 400) begin
      budget++;
      n_checks++;
      if (bus.req_ready !== 1'b0) $display("FAIL req_ready_busy: got %b want 0", bus.req_ready);
      else n_pass++;
      if (bus.mem_req_valid === 1'b1) begin
        a = bus.mem_req_addr;
        seen_addr.push_back(a);
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL mem_req_extra: got addr %h want no request", a);
        else begin
          e_a = exp_q.pop_front();
          if (a !== e_a) $display("FAIL mem_req_addr: got %h want %h", a, e_a);
          else n_pass++;
        end
        for (int s = 0; s < mem_stall; s++) begin
          bus.mem_req_ready = 1'b0;
          bus.mem_rsp_valid = 1'b1;
          bus.mem_rsp_data  = {$urandom, $urandom};
          @(negedge clk);
          bus.mem_rsp_valid = 1'b0;
          n_checks++;
          if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== a || bus.req_ready !== 1'b0)
            $display("FAIL mem_req_hold: got v=%b addr=%h rdy=%b want v=1 addr=%h rdy=0",
                     bus.mem_req_valid, bus.mem_req_addr, bus.req_ready, a);
          else n_pass++;
        end
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        n_checks++;
        if (bus.mem_req_valid !== 1'b0) $display("FAIL mem_req_drop: got %b want 0", bus.mem_req_valid);
        else n_pass++;
        repeat (rsp_delay) @(negedge clk);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = mem_rd(a);
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = {$urandom, $urandom};
        o_nacc++;
      end else if (bus.fill_valid === 1'b1) begin
        f_va = bus.fill_va; f_pcid = bus.fill_pcid; f_pa = bus.fill_pa;
        f_level = bus.fill_level; f_fault = bus.fill_fault;
        n_checks++;
        if (f_pa !== e_pa || f_level !== e_level || f_fault !== e_fault)
          $display("FAIL fill_entry: got pa=%h lvl=%0d flt=%b want pa=%h lvl=%0d flt=%b",
                   f_pa, f_level, f_fault, e_pa, e_level, e_fault);
        else n_pass++;
        n_checks++;
        if (f_va !== va || f_pcid !== pcid)
          $display("FAIL fill_echo: got va=%h pcid=%h want va=%h pcid=%h", f_va, f_pcid, va, pcid);
        else n_pass++;
        if (mem_stall == 0 && rsp_delay == 0) begin
          n_checks++;
          if (int'(cyc) - c0 !== 2 * e_n)
            $display("FAIL fill_latency: got %0d want %0d cycles after T+1", int'(cyc) - c0, 2 * e_n);
          else n_pass++;
        end
        for (int s = 0; s < fill_stall; s++) begin
          bus.fill_ready = 1'b0;
          @(negedge clk);
          n_checks++;
          if (bus.fill_valid !== 1'b1 || bus.fill_va !== f_va || bus.fill_pcid !== f_pcid ||
              bus.fill_pa !== f_pa || bus.fill_level !== f_level || bus.fill_fault !== f_fault ||
              bus.req_ready !== 1'b0)
            $display("FAIL fill_hold: got v=%b pa=%h lvl=%0d flt=%b rdy=%b want v=1 pa=%h lvl=%0d flt=%b rdy=0",
                     bus.fill_valid, bus.fill_pa, bus.fill_level, bus.fill_fault, bus.req_ready,
                     f_pa, f_level, f_fault);
          else n_pass++;
        end
        bus.fill_ready = 1'b1;
        @(negedge clk);
        bus.fill_ready = 1'b0;
        n_checks++;
        if (bus.fill_valid !== 1'b0 || bus.req_ready !== 1'b1)
          $display("FAIL fill_done: got v=%b rdy=%b want v=0 rdy=1", bus.fill_valid, bus.req_ready);
        else n_pass++;
        o_pa = f_pa; o_level = f_level; o_fault = f_fault;
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    n_checks++;
    if (!done) $display("FAIL walk_timeout: got no fill want fill within 400 cycles");
    else n_pass++;
    n_checks++;
    if (o_nacc !== e_n || exp_q.size() != 0)
      $display("FAIL mem_access_count: got %0d want %0d (unissued %0d)", o_nacc, e_n, exp_q.size());
    else n_pass++;
  endtask

  task automatic setup_4k();
    pt_mem.delete();
    pt_mem[64'h10007F8] = 64'h2001;
    pt_mem[64'h2FF8]    = 64'h3001;
    pt_mem[64'h3FF8]    = 64'h4001;
    pt_mem[64'h4FF8]    = 64'hABCD001;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.req_valid = 0; bus.req_va = '0; bus.req_pcid = '0; bus.root_ppn = '0;
    bus.mem_req_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_data = '0; bus.fill_ready = 0;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 0 || bus.mem_req_valid !== 0 || bus.mem_req_addr !== 0 || bus.fill_valid !== 0 ||
        bus.fill_va !== 0 || bus.fill_pcid !== 0 || bus.fill_pa !== 0 || bus.fill_level !== 0 || bus.fill_fault !== 0)
      $display("FAIL reset_outputs: got rdy=%b mv=%b fv=%b pa=%h want all 0",
               bus.req_ready, bus.mem_req_valid, bus.fill_valid, bus.fill_pa);
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b0) $display("FAIL reset_release_ready: got %b want 0", bus.req_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL reset_ready_rise: got %b want 1", bus.req_ready);
    else n_pass++;
  endtask

  task automatic test_walk_4k();
    logic [63:0] spec_addr [4] = '{64'h10007F8, 64'h2FF8, 64'h3FF8, 64'h4FF8};
    logic [63:0] pa; logic [1:0] lvl; logic flt; int n;
    setup_4k();
    run_walk(64'h00007FFFFFFFF123, 12'h5A5, 40'h1000, 0, 0, 0, pa, lvl, flt, n);
    n_checks++;
    if (pa !== 64'hABCD123 || lvl !== 2'd0 || flt !== 1'b0 || n !== 4)
      $display("FAIL walk_4k: got pa=%h lvl=%0d flt=%b n=%0d want pa=abcd123 lvl=0 flt=0 n=4", pa, lvl, flt, n);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= seen_addr.size()) $display("FAIL walk_4k_addr%0d: got none want %h", i, spec_addr[i]);
      else if (seen_addr[i] !== spec_addr[i])
        $display("FAIL walk_4k_addr%0d: got %h want %h", i, seen_addr[i], spec_addr[i]);
      else n_pass++;
    end
  endtask

  task automatic test_2m();
    logic [63:0] pa; logic [1:0] lvl; logic flt; int n;
    setup_4k();
    pt_mem[64'h3FF8] = 64'h40000081;
    run_walk(64'h00007FFFFFFFF123, 12'h0C3, 40'h1000, 0, 0, 0, pa, lvl, flt, n);
    n_checks++;
    if (pa !== 64'h401FF123 || lvl !== 2'd1 || flt !== 1'b0 || n !== 3)
      $display("FAIL walk_2m: got pa=%h lvl=%0d flt=%b n=%0d want pa=401ff123 lvl=1 flt=0 n=3", pa, lvl, flt, n);
    else n_pass++;
  endtask

  task automatic test_not_present();
    logic [63:0] pa; logic [1:0] lvl; logic flt; int n;
    setup_4k();
    pt_mem[64'h2FF8] = 64'h0;
    run_walk(64'h00007FFFFFFFF123, 12'h111, 40'h1000, 0, 0, 0, pa, lvl, flt, n);
    n_checks++;
    if (pa !== 64'h0 || lvl !== 2'd2 || flt !== 1'b1 || n !== 2)
      $display("FAIL not_present: got pa=%h lvl=%0d flt=%b n=%0d want pa=0 lvl=2 flt=1 n=2", pa, lvl, flt, n);
    else n_pass++;
  endtask

  task automatic test_noncanonical();
    logic [63:0] pa; logic [1:0] lvl; logic flt; int n;
    setup_4k();
    run_walk(64'h0000800000000000, 12'h7FF, 40'h1000, 0, 0, 0, pa, lvl, flt, n);
    n_checks++;
    if (pa !== 64'h0 || lvl !== 2'd3 || flt !== 1'b1 || n !== 0 || seen_addr.size() != 0)
      $display("FAIL noncanonical: got pa=%h lvl=%0d flt=%b n=%0d want pa=0 lvl=3 flt=1 n=0", pa, lvl, flt, n);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [63:0] pa; logic [1:0] lvl; logic flt; int n, extra;
    setup_4k();
    run_walk(64'h00007FFFFFFFF123, 12'h2B2, 40'h1000, 3, 1, 5, pa, lvl, flt, n);
    n_checks++;
    if (pa !== 64'hABCD123 || lvl !== 2'd0 || flt !== 1'b0)
      $display("FAIL backpressure_fill: got pa=%h lvl=%0d flt=%b want pa=abcd123 lvl=0 flt=0", pa, lvl, flt);
    else n_pass++;
    extra = 0;
    bus.fill_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.fill_valid === 1'b1) extra++;
    end
    bus.fill_ready = 1'b0;
    n_checks++;
    if (extra != 0) $display("FAIL backpressure_single_fill: got %0d extra fills want 0", extra);
    else n_pass++;
  endtask

  task automatic test_reset_mid_walk();
    logic [63:0] pa; logic [1:0] lvl; logic flt; int n, budget;
    setup_4k();
    budget = 0;
    while (bus.req_ready !== 1'b1 && budget < 50) begin @(negedge clk); budget++; end
    bus.req_valid = 1'b1; bus.req_va = 64'h00007FFFFFFFF123; bus.req_pcid = 12'h3C3; bus.root_ppn = 40'h1000;
    @(negedge clk);
    bus.req_valid = 1'b0;
    budget = 0;
    while (bus.mem_req_valid !== 1'b1 && budget < 50) begin @(negedge clk); budget++; end
    n_checks++;
    if (bus.mem_req_valid !== 1'b1) $display("FAIL rst_mid_start: got mem_req_valid=%b want 1", bus.mem_req_valid);
    else n_pass++;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 0 || bus.mem_req_valid !== 0 || bus.mem_req_addr !== 0 || bus.fill_valid !== 0 ||
        bus.fill_va !== 0 || bus.fill_pcid !== 0 || bus.fill_pa !== 0 || bus.fill_level !== 0 || bus.fill_fault !== 0)
      $display("FAIL rst_mid_outputs: got rdy=%b mv=%b addr=%h fv=%b va=%h want all 0",
               bus.req_ready, bus.mem_req_valid, bus.mem_req_addr, bus.fill_valid, bus.fill_va);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b want 1", bus.req_ready);
    else n_pass++;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 64'hABCD001;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.mem_req_valid !== 1'b0 || bus.fill_valid !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL rst_mid_stray: got mv=%b fv=%b rdy=%b want mv=0 fv=0 rdy=1",
               bus.mem_req_valid, bus.fill_valid, bus.req_ready);
    else n_pass++;
    run_walk(64'h00007FFFFFFFF123, 12'h3C3, 40'h1000, 0, 0, 0, pa, lvl, flt, n);
    n_checks++;
    if (pa !== 64'hABCD123 || lvl !== 2'd0 || flt !== 1'b0 || n !== 4)
      $display("FAIL rst_mid_rewalk: got pa=%h lvl=%0d flt=%b n=%0d want pa=abcd123 lvl=0 flt=0 n=4", pa, lvl, flt, n);
    else n_pass++;
  endtask

  // Random tables: each level may be absent, a large-page leaf, or a pointer.
  task automatic build_random(input logic [63:0] va, input logic [39:0] root);
    logic [63:0] base, a, pte;
    int r;
    bit stop;
    pt_mem.delete();
    base = {24'd0, root} << 12;
    stop = 0;
    for (int l = 3; l >= 0 && !stop; l--) begin
      a   = base + (((va >> (12 + 9 * l)) & 64'h1FF) * 8);
      pte = {$urandom, $urandom};
      r   = $urandom_range(0, 99);
      pte[0] = (r >= 8);
      if (l == 3)      pte[7] = (r >= 8 && r < 14);
      else if (l != 0) pte[7] = (r >= 8 && r < 40);
      pt_mem[a] = pte;
      if (!pte[0] || (l != 0 && pte[7])) stop = 1;
      base = pte & PTE_PPN_MASK;
    end
  endtask

  task automatic test_random();
    logic [63:0] va, pa; logic [1:0] lvl; logic flt; int n, ms, rd, fs;
    logic [39:0] root;
    for (int i = 0; i < 40; i++) begin
      va = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) va[63] = ~va[47];
      else va[63:48] = {16{va[47]}};
      root = {8'($urandom), 32'($urandom)};
      build_random(va, root);
      if ($urandom_range(0, 2) == 0) begin ms = 0; rd = 0; fs = 0; end
      else begin ms = $urandom_range(0, 3); rd = $urandom_range(0, 2); fs = $urandom_range(0, 3); end
      run_walk(va, 12'($urandom_range(0, 4095)), root, ms, rd, fs, pa, lvl, flt, n);
    end
  endtask

  initial begin
    test_reset();
    test_walk_4k();
    test_2m();
    test_not_present();
    test_noncanonical();
    test_backpressure();
    test_reset_mid_walk();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tlb_walker.md
Name: tlb_walker

Overview:
- Page-table walker that services TLB misses: takes a missed virtual address and PCID, walks a 4-level radix page table (PML4 → PDPT → PD → PT, 9 index bits per level) and returns a fill entry.
- Sits between the `cache` TLB lookup block and the memory port; it is the miss responder for the TLB lookup path.
- Supports one walk in flight and 64-bit PTEs.

Parameters:
- PCID_W, 12, PCID width; matches the TLB `in_pcid` port.
- PPN_W, 40, physical page number width; PTE bits [51:12].
- ADDR_W, 64, virtual and physical address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  miss request valid.
- req_ready  out  1  walker idle and able to accept a request.
- req_va  in  ADDR_W  missed virtual address.
- req_pcid  in  PCID_W  PCID of the miss.
- root_ppn  in  PPN_W  PML4 base PPN; sampled at request accept.
- mem_req_valid  out  1  PTE read request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDR_W  PTE physical byte address.
- mem_rsp_valid  in  1  PTE data valid.
- mem_rsp_data  in  64  PTE.
- fill_valid  out  1  fill entry valid.
- fill_ready  in  1  TLB accepts fill.
- fill_va  out  ADDR_W  original req_va.
- fill_pcid  out  PCID_W  original req_pcid.
- fill_pa  out  ADDR_W  translated physical address; 0 on fault.
- fill_level  out  2  leaf level: 0 = 4K, 1 = 2M, 2 = 1G; level at which the fault occurred on fault.
- fill_fault  out  1  translation fault.

Behaviour:
- States: IDLE, ISSUE, WAIT, FILL.
- Reset (async, rst_n = 0): state IDLE; all outputs 0, including req_ready.
  - req_ready rises at the first clk edge after rst_n deasserts.
  - A walk in progress is abandoned; any later mem_rsp_valid is ignored until a new ISSUE.
- IDLE: req_ready = 1. On req_valid && req_ready:
  - Latch va, pcid and root_ppn; set lvl = 3; drop req_ready.
  - Non-canonical va (bits [63:47] not all equal): go directly to FILL with fault = 1, level = 3. No memory access.
  - Otherwise go to ISSUE.
- ISSUE:
  - mem_req_valid = 1; mem_req_addr = {table_ppn, idx[lvl], 3'b000}, zero-extended.
  - idx[3] = va[47:39], idx[2] = va[38:30], idx[1] = va[29:21], idx[0] = va[20:12].
  - Address and valid held stable while mem_req_ready = 0.
  - On handshake go to WAIT; mem_req_valid drops next cycle.
- WAIT: the first cycle with mem_rsp_valid = 1 consumes the PTE.
  - pte[0] = 0 → FILL, fault = 1, level = lvl.
  - Leaf when lvl == 0, or pte[7] = 1 with lvl ∈ {1, 2} → FILL, fault = 0.
    - pa = {pte[51:12+9·lvl], va[11+9·lvl:0]}, zero-extended; level = lvl.
  - pte[7] = 1 at lvl 3 → fault, level = 3.
  - Otherwise table_ppn = pte[51:12], lvl −= 1, go to ISSUE.
- mem_rsp_valid outside WAIT is ignored.
- FILL:
  - fill_valid = 1; all fill_* outputs are registered and held stable until fill_ready.
  - On handshake go to IDLE; req_ready = 1 the following cycle.
  - On fault, fill_pa = 0.
- Latency with zero-wait memory (ready always 1, response the cycle after the request handshake):
  - Accept at edge T; first mem_req_valid during cycle T+1; fill_valid 2·N+1 cycles after accept, N = memory accesses performed.
  - Non-canonical fault: fill_valid during cycle T+1.
- Never more than one outstanding memory request. req_ready is 0 in every state except IDLE.

Test Plan:
- 4K walk, root_ppn = 0x1000, va = 0x00007FFFFFFFF123:
  - Required mem_req_addr sequence: 0x10007F8, 0x2FF8, 0x3FF8, 0x4FF8.
  - Respond with PTEs 0x2001, 0x3001, 0x4001, 0xABCD001.
  - Expect fill_pa = 0xABCD123, fill_level = 0, fill_fault = 0, fill_pcid echoed.
- 2M page, same va: level-1 PTE = 0x40000081 → fill_pa = 0x401FF123, fill_level = 1, exactly 3 memory requests.
- Not-present fault: level-2 PTE = 0x0 → fill_fault = 1, fill_pa = 0, fill_level = 2, exactly 2 memory requests.
- Non-canonical va = 0x0000800000000000 → fill_fault = 1, fill_level = 3 one cycle after accept; mem_req_valid never asserts.
- Backpressure: mem_req_ready low 3 cycles, then fill_ready low 5 cycles.
  - mem_req_addr and fill_* stay stable throughout; req_ready stays 0.
  - Only one fill handshake occurs.
- Reset mid-walk: assert rst_n = 0 in WAIT, then drive a stray mem_rsp_valid after release.
  - Outputs go to 0 immediately; req_ready = 1 after release; the stray response is ignored; a new walk completes correctly.
